bram_mux_lp: RTL and testbench

Parametrised low-power block RAM with a registered pass-through output mux. It is the next generation of the team's single-port 2K×8 BRAM/bypass mux. It adds configurable width and depth, an explicit read strobe and a valid flag, and idle-driven RAM sleep with a ready handshake. It sits between a datapath master and on-chip storage. The output either returns RAM data or a bypass word, with sources time-aligned, and RAM enables are gated off whenever the RAM is not needed.

---
 rtl/bram_mux_lp.sv | 154 +++++++++++++++
 tb/tb_bram_mux_lp.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bram_mux_lp.sv
// Purpose: parametrised single-port BRAM with registered RAM/bypass output mux and optional idle sleep (BRAM_SLEEP_EN).
// Latency: any accepted read (RAM or pass-through) appears on dout/dout_vld two clocks after it is presented.
// Backpressure: rdy=0 while asleep/waking drops RAM requests (master must hold them); pass-through reads never stall.
module bram_mux_lp #(
    parameter int DW          = 8,
    parameter int AW          = 11,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic          sel,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    input  logic [DW-1:0] pass_ip,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic          rdy
);

    if (DW < 1 || IDLE_CYCLES < 1 || WAKE_CYCLES < 1) begin : g_param_err
        $error("bram_mux_lp: DW, IDLE_CYCLES and WAKE_CYCLES must all be >= 1");
    end

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] temp;
    logic [DW-1:0] pass_d1;
    logic          sel_d1;
    logic          vld_d1;

    logic ram_we;
    logic ram_re;
    logic pass_rd;

    // RAM enables only fire for requests the RAM is able to accept this cycle
    assign ram_we  = we & rdy;
    assign ram_re  = re & sel & rdy;
    assign pass_rd = re & ~sel;

`ifdef BRAM_SLEEP_EN
    typedef enum logic [1:0] {ST_ACTIVE, ST_SLEEP, ST_WAKE} state_t;

    localparam int ICW = $clog2(IDLE_CYCLES + 1);
    localparam int WCW = $clog2(WAKE_CYCLES + 1);
    localparam logic [ICW-1:0] IDLE_LAST = ICW'(IDLE_CYCLES - 1);
    localparam logic [WCW-1:0] WAKE_LOAD = WCW'(WAKE_CYCLES - 1);

    logic           ram_req;
    state_t         state, state_nxt;
    logic [ICW-1:0] idle_cnt, idle_cnt_nxt;
    logic [WCW-1:0] wake_cnt, wake_cnt_nxt;

    // Pass-through reads deliberately do not count as RAM activity
    assign ram_req = we | (re & sel);

    // Sleep controller state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_ACTIVE;
            idle_cnt <= '0;
            wake_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_cnt_nxt;
            wake_cnt <= wake_cnt_nxt;
        end
    end

    // Idle counting, sleep entry on the last idle cycle, fixed-length wake
    always_comb begin
        state_nxt    = state;
        idle_cnt_nxt = idle_cnt;
        wake_cnt_nxt = wake_cnt;
        case (state)
            ST_ACTIVE: begin
                if (ram_req) begin
                    idle_cnt_nxt = '0;
                end else if (idle_cnt == IDLE_LAST) begin
                    state_nxt    = ST_SLEEP;
                    idle_cnt_nxt = '0;
                end else begin
                    idle_cnt_nxt = idle_cnt + ICW'(1);
                end
            end
            ST_SLEEP: begin
                if (ram_req) begin
                    state_nxt    = ST_WAKE;
                    wake_cnt_nxt = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                // Requests seen here are ignored so the wake time stays fixed
                if (wake_cnt == '0) begin
                    state_nxt    = ST_ACTIVE;
                    idle_cnt_nxt = '0;
                end else begin
                    wake_cnt_nxt = wake_cnt - WCW'(1);
                end
            end
            default: begin
                state_nxt    = ST_ACTIVE;
                idle_cnt_nxt = '0;
            end
        endcase
    end

    assign rdy = (state == ST_ACTIVE);
`else
    assign rdy = 1'b1;
`endif

    // RAM array: read-first on same-address write/read, contents never reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[addr] <= din;
        end
        if (ram_re) begin
            temp <= mem[addr];
        end
    end

    // Stage 1: align source select and bypass word with the RAM read
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_d1  <= 1'b0;
            sel_d1  <= 1'b0;
            pass_d1 <= '0;
        end else begin
            vld_d1 <= ram_re | pass_rd;
            if (ram_re | pass_rd) begin
                sel_d1 <= sel;
            end
            if (pass_rd) begin
                pass_d1 <= pass_ip;
            end
        end
    end

    // Stage 2: output register only updates on a valid beat so dout never toggles idly
    always_ff @(posedge clk) begin
        if (rst) begin
            dout     <= '0;
            dout_vld <= 1'b0;
        end else begin
            dout_vld <= vld_d1;
            if (vld_d1) begin
                dout <= sel_d1 ? temp : pass_d1;
            end
        end
    end

endmodule

// File: tb/tb_bram_mux_lp.sv
// Directed vector bench for bram_mux_lp (DW=8, AW=4, IDLE_CYCLES=4, WAKE_CYCLES=2).
// Each vector is driven for one cycle; expected outputs are those visible during that cycle.
// Expectations for rdy / RAM enables follow whether BRAM_SLEEP_EN is compiled in.
module tb_bram_mux_lp;

    logic       clk;
    logic       rst;
    logic       we;
    logic       re;
    logic       sel;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] pass_ip;
    logic [7:0] dout;
    logic       dout_vld;
    logic       rdy;

    int n_pass;
    int n_total;

`ifdef BRAM_SLEEP_EN
    localparam logic RS = 1'b0;
`else
    localparam logic RS = 1'b1;
`endif

    bram_mux_lp #(
        .DW(8),
        .AW(4),
        .IDLE_CYCLES(4),
        .WAKE_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .we(we),
        .re(re),
        .sel(sel),
        .addr(addr),
        .din(din),
        .pass_ip(pass_ip),
        .dout(dout),
        .dout_vld(dout_vld),
        .rdy(rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       we;
        logic       re;
        logic       sel;
        logic [3:0] addr;
        logic [7:0] din;
        logic [7:0] pass;
        logic [7:0] dout;
        logic       vld;
        logic       rdy;
        logic       ren;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic w, input logic rd, input logic s,
                                input logic [3:0] a, input logic [7:0] d, input logic [7:0] p,
                                input logic [7:0] e_dout, input logic e_vld, input logic e_rdy,
                                input logic e_ren);
        vec_t v;
        v.rst = r;  v.we = w;  v.re = rd;  v.sel = s;  v.addr = a;  v.din = d;  v.pass = p;
        v.dout = e_dout;  v.vld = e_vld;  v.rdy = e_rdy;  v.ren = e_ren;
        return v;
    endfunction

    task automatic check(input string name, input int step, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s step=%0d got=%h expected=%h", name, step, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic rd, input logic s,
                         input logic [3:0] a, input logic [7:0] d, input logic [7:0] p);
        rst = r;  we = w;  re = rd;  sel = s;  addr = a;  din = d;  pass_ip = p;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        //          rst we re sel addr  din    pass    dout   vld rdy ren
        tbl.push_back(mk(0, 1, 0, 0, 4'd3, 8'h5A, 8'h00, 8'h00, 0, 1, 1));   // 0  write 5A @3
        tbl.push_back(mk(0, 0, 1, 1, 4'd3, 8'h00, 8'h00, 8'h00, 0, 1, 1));   // 1  read @3
        tbl.push_back(mk(0, 0, 0, 0, 4'd0, 8'h00, 8'h00, 8'h00, 0, 1, 0));   // 2
        tbl.push_back(mk(0, 0, 0, 0, 4'd0, 8'h00, 8'h00, 8'h5A, 1, 1, 0));   // 3  read result
        tbl.push_back(mk(0, 0, 1, 1, 4'd3, 8'h00, 8'h00, 8'h5A, 0, 1, 1));   // 4  RAM read
        tbl.push_back(mk(0, 0, 1, 0, 4'd0, 8'h00, 8'hC3, 8'h5A, 0, 1, 0));   // 5  pass C3
        tbl.push_back(mk(0, 0, 1, 1, 4'd3, 8'h00, 8'h00, 8'h5A, 1, 1, 1));   // 6  RAM read
        tbl.push_back(mk(0, 1, 1, 1, 4'd3, 8'h11, 8'h00, 8'hC3, 1, 1, 1));   // 7  write 11 + read @3
        tbl.push_back(mk(0, 0, 1, 1, 4'd3, 8'h00, 8'h00, 8'h5A, 1, 1, 1));   // 8  read @3
        tbl.push_back(mk(0, 0, 0, 0, 4'd0, 8'h00, 8'h00, 8'h5A, 1, 1, 0));   // 9  old data
        tbl.push_back(mk(0, 0, 0, 0, 4'd0, 8'h00, 8'h00, 8'h11, 1, 1, 0));   // 10 new data
        tbl.push_back(mk(0, 0, 0, 0, 4'd0, 8'h00, 8'h00, 8'h11, 0, 1, 0));   // 11
        tbl.push_back(mk(0, 0, 0, 0, 4'd0, 8'h00, 8'h00, 8'h11, 0, 1, 0));   // 12 4th idle
        tbl.push_back(mk(0, 1, 0, 0, 4'd5, 8'h77, 8'h00, 8'h11, 0, RS, RS)); // 13 write 77 @5, asleep
        tbl.push_back(mk(0, 1, 0, 0, 4'd5, 8'h77, 8'h00, 8'h11, 0, RS, RS)); // 14 waking
        tbl.push_back(mk(0, 1, 0, 0, 4'd5, 8'h77, 8'h00, 8'h11, 0, RS, RS)); // 15 waking
        tbl.push_back(mk(0, 1, 0, 0, 4'd5, 8'h77, 8'h00, 8'h11, 0, 1, 1));   // 16 accepted
        tbl.push_back(mk(0, 0, 1, 1, 4'd5, 8'h00, 8'h00, 8'h11, 0, 1, 1));   // 17 read @5
        tbl.push_back(mk(0, 0, 0, 0, 4'd0, 8'h00, 8'h00, 8'h11, 0, 1, 0));   // 18
        tbl.push_back(mk(0, 0, 0, 0, 4'd0, 8'h00, 8'h00, 8'h77, 1, 1, 0));   // 19
        tbl.push_back(mk(0, 0, 0, 0, 4'd0, 8'h00, 8'h00, 8'h77, 0, 1, 0));   // 20
        tbl.push_back(mk(0, 0, 0, 0, 4'd0, 8'h00, 8'h00, 8'h77, 0, 1, 0));   // 21 4th idle
        tbl.push_back(mk(0, 0, 1, 0, 4'd0, 8'h00, 8'h9E, 8'h77, 0, RS, 0));  // 22 pass 9E asleep
        tbl.push_back(mk(0, 0, 0, 0, 4'd0, 8'h00, 8'h00, 8'h77, 0, RS, 0));  // 23
        tbl.push_back(mk(0, 0, 0, 0, 4'd0, 8'h00, 8'h00, 8'h9E, 1, RS, 0));  // 24
        tbl.push_back(mk(0, 1, 0, 0, 4'd7, 8'h33, 8'h00, 8'h9E, 0, RS, RS)); // 25 request -> wake
        tbl.push_back(mk(1, 0, 0, 0, 4'd0, 8'h00, 8'h00, 8'h9E, 0, RS, 0));  // 26 reset while waking
        tbl.push_back(mk(0, 0, 0, 0, 4'd0, 8'h00, 8'h00, 8'h00, 0, 1, 0));   // 27
        tbl.push_back(mk(0, 0, 1, 1, 4'd5, 8'h00, 8'h00, 8'h00, 0, 1, 1));   // 28 read @5
        tbl.push_back(mk(0, 0, 0, 0, 4'd0, 8'h00, 8'h00, 8'h00, 0, 1, 0));   // 29
        tbl.push_back(mk(0, 0, 0, 0, 4'd0, 8'h00, 8'h00, 8'h77, 1, 1, 0));   // 30 preserved

        // Reset state
        drive(1, 0, 0, 0, 4'd0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_dout", -1, dout, 8'h00);
        check("reset_vld", -1, {7'd0, dout_vld}, 8'h00);
        check("reset_rdy", -1, {7'd0, rdy}, 8'h01);

        // Table vectors
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i].rst, tbl[i].we, tbl[i].re, tbl[i].sel, tbl[i].addr, tbl[i].din, tbl[i].pass);
            @(negedge clk);
            check("dout", i, dout, tbl[i].dout);
            check("dout_vld", i, {7'd0, dout_vld}, {7'd0, tbl[i].vld});
            check("rdy", i, {7'd0, rdy}, {7'd0, tbl[i].rdy});
            check("ram_en", i, {7'd0, dut.ram_re | dut.ram_we}, {7'd0, tbl[i].ren});
        end

        // Reset one cycle after a RAM read drops the in-flight beat
        @(posedge clk);
        #1;
        drive(0, 0, 1, 1, 4'd5, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        drive(1, 0, 0, 0, 4'd0, 8'h00, 8'h00);
        @(negedge clk);
        check("midrd_pre_vld", 0, {7'd0, dout_vld}, 8'h00);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 4'd0, 8'h00, 8'h00);
        @(negedge clk);
        check("midrd_dout", 1, dout, 8'h00);
        check("midrd_vld", 1, {7'd0, dout_vld}, 8'h00);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrd_vld_late", 2, {7'd0, dout_vld}, 8'h00);

        // Back-to-back pass-through then RAM read after the reset: order preserved
        @(posedge clk);
        #1;
        drive(0, 0, 1, 0, 4'd0, 8'h00, 8'hA5);
        @(posedge clk);
        #1;
        drive(0, 0, 1, 1, 4'd3, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 4'd0, 8'h00, 8'h00);
        @(negedge clk);
        check("b2b_first", 0, dout, 8'hA5);
        check("b2b_first_vld", 0, {7'd0, dout_vld}, 8'h01);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("b2b_second", 1, dout, 8'h11);
        check("b2b_second_vld", 1, {7'd0, dout_vld}, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
